// File: rtl/lbdr_parity_scheduler_pkg.sv
// Shared definitions for the LBDR parity-check scheduler.
// Holds the port numbering, the default port count and the width of an encoded port index.
package lbdr_parity_scheduler_pkg;

   localparam int NUM_PORTS = 5;
   localparam int PORT_W    = 3;

   // Input FIFO numbering used by rx_flat, empty, pop, grant and check_port.
   typedef enum logic [PORT_W-1:0] {
      NORTH = 3'd0,
      EAST  = 3'd1,
      WEST  = 3'd2,
      SOUTH = 3'd3,
      LOCAL = 3'd4
   } port_e;

endpackage

// File: rtl/lbdr_rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first requesting port at or after ptr, wrapping modulo NUM_PORTS.
// Ports:
//   req    - per-port request vector
//   ptr    - port index where the search starts
//   gnt    - one-hot grant, all zero when nothing requests
//   winner - encoded index of the granted port (0 when valid=0)
//   valid  - some port was granted
module lbdr_rr_arbiter #(
   parameter int NUM_PORTS = lbdr_parity_scheduler_pkg::NUM_PORTS
) (
   input  logic [NUM_PORTS-1:0]                        req,
   input  logic [lbdr_parity_scheduler_pkg::PORT_W-1:0] ptr,
   output logic [NUM_PORTS-1:0]                        gnt,
   output logic [lbdr_parity_scheduler_pkg::PORT_W-1:0] winner,
   output logic                                        valid
);
   import lbdr_parity_scheduler_pkg::*;

   logic [PORT_W-1:0] idx;

   always_comb begin
      gnt    = '0;
      winner = '0;
      valid  = 1'b0;
      idx    = '0;
      // Scan ports in rotated order; the first hit wins.
      for (int i = 0; i < NUM_PORTS; i++) begin
         idx = PORT_W'((int'(ptr) + i) % NUM_PORTS);
         if (!valid && req[idx]) begin
            valid    = 1'b1;
            winner   = idx;
            gnt[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/lbdr_parity_scheduler.sv
// Shared parity-check scheduler for the router input FIFOs.
// Each FIFO head flit is checked once, in round-robin order, through a two-stage pipeline:
// stage 1 holds the granted flit, stage 2 reports the even-parity result.
// Ports:
//   clk, reset     - rising-edge clock, asynchronous active-low reset
//   rx_flat        - FIFO head flits, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   empty, pop     - FIFO empty flags and read strobes
//   clear          - synchronous clear of fault counters and sticky flags
//   grant          - one-hot port whose flit sits in stage 1
//   check_valid    - one-cycle result pulse, with check_port and check_faulty
//   fault_cnt_flat - saturating per-port fault counters, port i at [i*CNT_WIDTH +: CNT_WIDTH]
//   port_faulty    - sticky per-port fault flags
module lbdr_parity_scheduler #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_PORTS  = lbdr_parity_scheduler_pkg::NUM_PORTS,
   parameter int CNT_WIDTH  = 4,
   parameter int THRESHOLD  = 3
) (
   input  logic                                        clk,
   input  logic                                        reset,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]             rx_flat,
   input  logic [NUM_PORTS-1:0]                        empty,
   input  logic [NUM_PORTS-1:0]                        pop,
   input  logic                                        clear,
   output logic [NUM_PORTS-1:0]                        grant,
   output logic                                        check_valid,
   output logic [lbdr_parity_scheduler_pkg::PORT_W-1:0] check_port,
   output logic                                        check_faulty,
   output logic [NUM_PORTS*CNT_WIDTH-1:0]              fault_cnt_flat,
   output logic [NUM_PORTS-1:0]                        port_faulty
);
   import lbdr_parity_scheduler_pkg::*;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] THRESH  = CNT_WIDTH'(THRESHOLD);

   logic [NUM_PORTS-1:0]                 req;
   logic [NUM_PORTS-1:0]                 arb_gnt;
   logic [PORT_W-1:0]                    arb_winner;
   logic                                 arb_valid;
   logic [PORT_W-1:0]                    ptr_q, ptr_d;
   logic [NUM_PORTS-1:0]                 checked_q, checked_d;
   logic                                 s1_valid_q;
   logic [NUM_PORTS-1:0]                 s1_gnt_q;
   logic [PORT_W-1:0]                    s1_port_q;
   logic [DATA_WIDTH-1:0]                s1_flit_q, s1_flit_d;
   logic [NUM_PORTS-1:0][CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [NUM_PORTS-1:0]                 faulty_q, faulty_d;

   // A head is eligible only once until it is popped.
   assign req = ~empty & ~checked_q;

   lbdr_rr_arbiter #(
      .NUM_PORTS (NUM_PORTS)
   ) u_arbiter (
      .req    (req),
      .ptr    (ptr_q),
      .gnt    (arb_gnt),
      .winner (arb_winner),
      .valid  (arb_valid)
   );

   always_comb begin
      ptr_d = ptr_q;
      if (arb_valid) begin
         ptr_d = (arb_winner == PORT_W'(NUM_PORTS - 1)) ? PORT_W'(NORTH) : arb_winner + 1'b1;
      end
   end

   // Pop wins over a same-cycle grant so the next head is eligible straight away.
   assign checked_d = (checked_q | arb_gnt) & ~pop;

   always_comb begin
      s1_flit_d = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (arb_gnt[i]) s1_flit_d = rx_flat[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_comb begin
      cnt_d    = cnt_q;
      faulty_d = faulty_q;
      if (clear) begin
         cnt_d    = '0;
         faulty_d = '0;
      end else if (check_valid && check_faulty) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (check_port == PORT_W'(i)) begin
               if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + 1'b1;
               if (cnt_d[i] >= THRESH) faulty_d[i] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_q        <= PORT_W'(NORTH);
         checked_q    <= '0;
         s1_valid_q   <= 1'b0;
         s1_gnt_q     <= '0;
         s1_port_q    <= '0;
         s1_flit_q    <= '0;
         check_valid  <= 1'b0;
         check_port   <= '0;
         check_faulty <= 1'b0;
         cnt_q        <= '0;
         faulty_q     <= '0;
      end else begin
         ptr_q        <= ptr_d;
         checked_q    <= checked_d;
         s1_valid_q   <= arb_valid;
         s1_gnt_q     <= arb_gnt;
         s1_port_q    <= arb_winner;
         s1_flit_q    <= s1_flit_d;
         check_valid  <= s1_valid_q;
         check_port   <= s1_port_q;
         check_faulty <= (^s1_flit_q[DATA_WIDTH-1:1]) != s1_flit_q[0];
         cnt_q        <= cnt_d;
         faulty_q     <= faulty_d;
      end
   end

   assign grant          = s1_gnt_q;
   assign fault_cnt_flat = cnt_q;
   assign port_faulty    = faulty_q;

endmodule

// File: tb/tb_lbdr_parity_scheduler.sv
// Self-checking bench for lbdr_parity_scheduler: directed scenarios with literal expectations,
// then randomized traffic compared cycle by cycle against a behavioural model.
module tb_lbdr_parity_scheduler;

   localparam int DW   = 32;
   localparam int NP   = 5;
   localparam int CW   = 4;
   localparam int THR  = 3;
   localparam int CMAX = 15;

   logic             clk = 1'b0;
   logic             reset;
   logic [31:0]      rx [NP];
   logic [NP*DW-1:0] rx_flat;
   logic [NP-1:0]    empty;
   logic [NP-1:0]    pop;
   logic             clear;
   logic [NP-1:0]    grant;
   logic             check_valid;
   logic [2:0]       check_port;
   logic             check_faulty;
   logic [NP*CW-1:0] fault_cnt_flat;
   logic [NP-1:0]    port_faulty;

   int checks   = 0;
   int failures = 0;

   // Behavioural model state
   int          m_ptr;
   bit          m_checked [NP];
   bit          m_s1_v;
   int          m_s1_port;
   logic [31:0] m_s1_flit;
   bit          m_cv;
   int          m_cp;
   bit          m_cf;
   int          m_cnt [NP];
   bit          m_pf [NP];

   always #5 clk = ~clk;

   always_comb begin
      rx_flat = '0;
      for (int i = 0; i < NP; i++) rx_flat[i*DW +: DW] = rx[i];
   end

   lbdr_parity_scheduler #(
      .DATA_WIDTH (DW),
      .NUM_PORTS  (NP),
      .CNT_WIDTH  (CW),
      .THRESHOLD  (THR)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .rx_flat        (rx_flat),
      .empty          (empty),
      .pop            (pop),
      .clear          (clear),
      .grant          (grant),
      .check_valid    (check_valid),
      .check_port     (check_port),
      .check_faulty   (check_faulty),
      .fault_cnt_flat (fault_cnt_flat),
      .port_faulty    (port_faulty)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   function automatic logic [CW-1:0] cnt_of(input int i);
      return fault_cnt_flat[i*CW +: CW];
   endfunction

   task automatic model_reset();
      m_ptr = 0; m_s1_v = 0; m_s1_port = 0; m_s1_flit = '0;
      m_cv = 0; m_cp = 0; m_cf = 0;
      for (int i = 0; i < NP; i++) begin
         m_checked[i] = 0; m_cnt[i] = 0; m_pf[i] = 0;
      end
   endtask

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic model_step();
      int win;
      if (clear) begin
         for (int i = 0; i < NP; i++) begin m_cnt[i] = 0; m_pf[i] = 0; end
      end else if (m_cv && m_cf) begin
         if (m_cnt[m_cp] < CMAX) m_cnt[m_cp] = m_cnt[m_cp] + 1;
         if (m_cnt[m_cp] >= THR) m_pf[m_cp] = 1;
      end
      // A flit is bad when its total count of ones is odd.
      m_cv = m_s1_v;
      m_cp = m_s1_port;
      m_cf = ($countones(m_s1_flit) % 2) == 1;
      win = -1;
      for (int k = 0; k < NP; k++) begin
         int p;
         p = (m_ptr + k) % NP;
         if (win < 0 && !empty[p] && !m_checked[p]) win = p;
      end
      m_s1_v = (win >= 0);
      if (win >= 0) begin
         m_s1_port     = win;
         m_s1_flit     = rx[win];
         m_ptr         = (win + 1) % NP;
         m_checked[win] = 1;
      end
      for (int i = 0; i < NP; i++) if (pop[i]) m_checked[i] = 0;
   endtask

   task automatic compare_all();
      logic [NP-1:0] eg;
      logic [NP-1:0] epf;
      eg = m_s1_v ? (NP'(1) << m_s1_port) : '0;
      chk("grant", 32'(grant), 32'(eg));
      chk("check_valid", 32'(check_valid), 32'(m_cv));
      if (m_cv) begin
         chk("check_port", 32'(check_port), 32'(m_cp));
         chk("check_faulty", 32'(check_faulty), 32'(m_cf));
      end
      epf = '0;
      for (int i = 0; i < NP; i++) begin
         chk("fault_cnt", 32'(cnt_of(i)), 32'(m_cnt[i]));
         epf[i] = m_pf[i];
      end
      chk("port_faulty", 32'(port_faulty), 32'(epf));
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   task automatic flush();
      empty = '1; pop = '1;
      tick();
      pop = '0;
   endtask

   initial begin
      reset = 1'b0; clear = 1'b0; pop = '0; empty = '1;
      for (int i = 0; i < NP; i++) rx[i] = '0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_grant", 32'(grant), 0);
      chk("rst_check_valid", 32'(check_valid), 0);
      chk("rst_check_port", 32'(check_port), 0);
      chk("rst_check_faulty", 32'(check_faulty), 0);
      chk("rst_fault_cnt", 32'(fault_cnt_flat), 0);
      chk("rst_port_faulty", 32'(port_faulty), 0);
      compare_all();
      reset = 1'b1;

      // Good flit on port 2
      rx[2] = 32'h0000_0003; empty = 5'b11011;
      tick(); chk("good_grant", 32'(grant), 32'h04);
      tick(); chk("good_cv", 32'(check_valid), 1);
      chk("good_port", 32'(check_port), 2);
      chk("good_faulty", 32'(check_faulty), 0);
      repeat (3) begin
         tick(); chk("good_no_recheck", 32'({grant, check_valid}), 0);
      end
      pop = 5'b00100; tick(); pop = '0;
      tick(); chk("good_regrant_after_pop", 32'(grant), 32'h04);
      repeat (2) tick();
      flush();

      // Bad flit on port 0
      rx[0] = 32'h0000_0002; empty = 5'b11110;
      tick(); chk("bad_grant", 32'(grant), 32'h01);
      tick(); chk("bad_cv", 32'(check_valid), 1);
      chk("bad_port", 32'(check_port), 0);
      chk("bad_faulty", 32'(check_faulty), 1);
      empty = '1;
      tick(); chk("bad_cnt0", 32'(cnt_of(0)), 1);
      flush();

      // Fairness after reset
      reset = 1'b0; model_reset(); @(negedge clk); compare_all(); reset = 1'b1;
      for (int i = 0; i < NP; i++) rx[i] = '0;
      empty = '0;
      for (int k = 0; k < NP; k++) begin
         tick(); chk("fair_grant", 32'(grant), 32'(1 << k));
      end
      repeat (4) tick();
      chk("fair_idle_grant", 32'(grant), 0);
      chk("fair_idle_cv", 32'(check_valid), 0);
      flush();

      // Threshold and saturation on port 3
      rx[3] = 32'h0000_0001; empty = 5'b10111; pop = 5'b01000;
      repeat (4) tick();
      chk("thr_cnt3_2", 32'(cnt_of(3)), 2);
      chk("thr_pf3_before", 32'(port_faulty[3]), 0);
      tick();
      chk("thr_cnt3_3", 32'(cnt_of(3)), 3);
      chk("thr_pf3_set", 32'(port_faulty[3]), 1);
      repeat (20) tick();
      chk("sat_cnt3", 32'(cnt_of(3)), 15);
      chk("sat_pf3", 32'(port_faulty[3]), 1);
      empty = '1; pop = '0;
      repeat (3) tick();
      flush();

      // Clear racing a faulty result on port 1 with counter at 2
      rx[1] = 32'h0000_0002; empty = 5'b11101; pop = 5'b00010;
      repeat (4) tick();
      chk("clr_cv", 32'(check_valid), 1);
      chk("clr_port", 32'(check_port), 1);
      chk("clr_faulty", 32'(check_faulty), 1);
      chk("clr_cnt1_pre", 32'(cnt_of(1)), 2);
      clear = 1'b1; empty = '1; pop = '0;
      tick(); clear = 1'b0;
      chk("clr_cnt1_post", 32'(cnt_of(1)), 0);
      chk("clr_pf_post", 32'(port_faulty), 0);
      repeat (3) tick();
      flush();

      // Asynchronous reset with both stages busy
      for (int i = 0; i < NP; i++) rx[i] = $urandom;
      empty = '0;
      tick(); tick();
      chk("mid_s1_busy", 32'(|grant), 1);
      chk("mid_s2_busy", 32'(check_valid), 1);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_grant", 32'(grant), 0);
      chk("mid_rst_cv", 32'(check_valid), 0);
      chk("mid_rst_cnt", 32'(fault_cnt_flat), 0);
      model_reset();
      repeat (2) begin
         @(negedge clk);
         chk("mid_hold_cv", 32'(check_valid), 0);
      end
      reset = 1'b1;
      tick(); chk("mid_first_grant", 32'(grant), 32'h01);
      repeat (6) tick();

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < NP; i++) if (pop[i]) rx[i] = $urandom;
         for (int i = 0; i < NP; i++) begin
            pop[i]   = ($urandom_range(0, 3) == 0);
            empty[i] = ($urandom_range(0, 2) == 0);
         end
         clear = ($urandom_range(0, 59) == 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lbdr_parity_scheduler.md
Name: lbdr_parity_scheduler

Overview:
Shares one parity-check datapath among the router's input FIFOs (N, E, W, S, L). Each FIFO head flit is checked exactly once, in round-robin order. The block keeps per-port fault counters and a sticky faulty flag per port. It sits between the input FIFOs and the LBDR routing logic, and its status feeds the fault-handling logic.

Parameters:
DATA_WIDTH, 32, flit width; bit 0 is the even-parity bit over bits DATA_WIDTH-1..1
NUM_PORTS, 5, number of input FIFOs; index 0=N, 1=E, 2=W, 3=S, 4=L
CNT_WIDTH, 4, width of each per-port fault counter
THRESHOLD, 3, fault count at which port_faulty is set; must satisfy 1 <= THRESHOLD <= 2^CNT_WIDTH-1

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
rx_flat  in  NUM_PORTS*DATA_WIDTH  FIFO head flits; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
empty  in  NUM_PORTS  FIFO empty flags; 1 means the head is invalid
pop  in  NUM_PORTS  FIFO read strobes; the head changes after a cycle with pop[i]=1
clear  in  1  synchronous clear of counters and sticky flags
grant  out  NUM_PORTS  one-hot; identifies the port whose flit is in stage 1
check_valid  out  1  one-cycle pulse; a check result is available
check_port  out  3  port index of the result
check_faulty  out  1  1 when the checked flit has a parity error
fault_cnt_flat  out  NUM_PORTS*CNT_WIDTH  per-port saturating fault counters
port_faulty  out  NUM_PORTS  sticky per-port fault flags

Behaviour:
- Reset (reset=0, asynchronous): all of the following are 0: grant, check_valid, check_port, check_faulty, all counters, port_faulty, checked[], stage valid bits. Round-robin pointer resets to 0.
- A port requests when empty[i]=0 and checked[i]=0.
- Arbiter: round-robin starting at pointer ptr.
  - The first requesting port at or after ptr (modulo NUM_PORTS) wins.
  - After a grant, ptr becomes (winner+1) mod NUM_PORTS.
  - When there is no request, ptr is held.
- Stage 1 (edge after the request cycle T):
  - Captures the winner's flit and port index; s1_valid=1.
  - grant is asserted one-hot during cycle T+1; grant is 0 when s1_valid=0.
- Stage 2 (edge after T+1):
  - check_faulty = (XOR of flit[DATA_WIDTH-1:1]) != flit[0].
  - check_valid=1 during T+2, with check_port and check_faulty valid; check_valid is 0 on all other cycles.
- Throughput: one check per cycle, fully pipelined; there are no stalls.
- checked[i]:
  - Set at the edge where port i is granted.
  - Cleared at the edge where pop[i]=1.
  - Pop has priority when both occur in the same cycle, so the new head becomes eligible.
- Pop while port i's flit is in stage 1 or stage 2: the result is still reported; no cancellation.
- A head that becomes empty before being granted is never checked; no error is reported.
- Fault counter i increments at the edge where check_valid=1, check_faulty=1 and check_port=i. It saturates at 2^CNT_WIDTH-1 and never wraps.
- port_faulty[i] is set when counter i reaches THRESHOLD and stays set until clear or reset. Faulty ports continue to be checked.
- clear=1: zeroes all counters and port_faulty at the next edge.
  - It takes precedence over a simultaneous increment or set.
  - It does not affect ptr, checked[], pipeline contents or check outputs.
- check_port values >= NUM_PORTS never occur.

Decomposition:
- Shared package holds:
  - Port index constants: NORTH=0, EAST=1, WEST=2, SOUTH=3, LOCAL=4.
  - NUM_PORTS.
  - Port-index width constant (3).
- One sub-module, lbdr_rr_arbiter: combinational request vector plus ptr, producing a one-hot grant and an encoded winner. The pointer register stays in the top level.
- The parity XOR is computed inline in stage 2.

Test Plan:
- Good flit: after reset, empty=5'b11011, port 2 head=32'h0000_0003 -> grant=5'b00100 at T+1; check_valid at T+2 with check_port=2, check_faulty=0; no second check until pop[2] is pulsed.
- Bad flit: port 0 head=32'h0000_0002 -> check_faulty=1, check_port=0; fault_cnt[0]=1 the cycle after check_valid.
- Fairness: all five ports non-empty together after reset -> grant sequence 0,1,2,3,4 on consecutive cycles; five results at T+2..T+6; then no further grants without pops.
- Threshold and saturation: port 3 given 32'h0000_0001 repeatedly with a pop after each grant -> port_faulty[3]=1 after the 3rd fault; counter holds 15 after 16+ faults.
- Clear race: assert clear in the same cycle as a faulty check_valid on port 1 whose counter is 2 -> counter 0, port_faulty[1]=0, check_valid pulse still seen.
- Reset mid-operation: drive reset=0 while stage 1 and stage 2 are both valid -> grant and check_valid drop immediately (asynchronous) and no result appears afterwards. After release with all ports non-empty, the first grant is port 0 and all heads are re-checked.
